io_bus_arbiter: RTL and testbench
=================================

# io_bus_arbiter

Two-master arbiter for the memory-mapped I/O bus. It shares the single I/O slave port (switches, LEDs, two 7-segment displays at 0x00001000–0x0000100C) between the CPU data port (master 0) and the UART debug bridge (master 1). Arbitration is round-robin, and each master sees a req/ack handshake. Exactly one transaction is presented to the slave at a time, and the slave write-enable is asserted for exactly one cycle per write.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- m0_req, m1_req  in  1  master i requests a transaction
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_a, m1_a  in  AW  transaction address
- m0_wd, m1_wd  in  DW  write data
- m0_funct3, m1_funct3  in  3  access size/type, forwarded unchanged
- m0_ack, m1_ack  out  1  one-cycle completion pulse for master i
- m0_rd, m1_rd  out  DW  registered read data for master i
- s_we  out  1  slave write enable
- s_a  out  AW  slave address
- s_wd  out  DW  slave write data
- s_funct3  out  3  slave funct3
- s_rd  in  DW  slave combinational read data
- busy  out  1  high while the FSM is not in IDLE

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset state is IDLE.
- IDLE:
  - No request: stay in IDLE.
  - Any req high: pick the winner, latch its index into sel, go to ACCESS.
- Arbitration is round-robin on a last register (0 or 1):
  - If both masters request, the master that is not last wins.
  - If only one master requests, it wins.
  - last is updated to the winner on entry to ACCESS.
  - last resets to 1, so master 0 wins the first tie.
- ACCESS (exactly one cycle):
  - s_a, s_wd and s_funct3 are driven combinationally from the selected master's inputs.
  - s_we = selected master's we.
  - At the closing edge, s_rd is captured into m{sel}_rd. This capture also happens on writes.
  - Go to DONE.
- DONE (exactly one cycle):
  - m{sel}_ack = 1. The other master's ack stays 0.
  - Go to IDLE.
  - A new request sampled in IDLE on the following cycle starts a new transaction. A master that keeps req high after its ack therefore issues a back-to-back transaction.
- Outside ACCESS, s_we, s_a, s_wd and s_funct3 are all 0.
- Master inputs must stay stable from the req rise until ack.
  - A master that drops req after it has been granted does not abort the transaction: ACCESS and DONE complete normally.
  - The non-selected master's inputs are ignored until the next IDLE.
- m0_rd and m1_rd hold their value until that master's next ACCESS capture.
- busy = (state != IDLE).

## Timing
- Request-to-ack latency for an uncontended master: req high at edge N (sampled in IDLE) → ACCESS during cycle N+1 → ack high during cycle N+2 → IDLE at N+3.
- Read data is valid on m{sel}_rd in the same cycle ack is high.
- Maximum throughput is one transaction per 3 cycles.
- Worst-case wait for a master facing continuous contention is one competing transaction (3 cycles) plus its own 3 cycles.
- Reset values, applied asynchronously:
  - state = IDLE, last = 1, sel = 0
  - m0_ack = m1_ack = 0, m0_rd = m1_rd = 0
  - s_we = 0, s_a = 0, s_wd = 0, s_funct3 = 0
  - busy = 0
- Reset asserted during ACCESS drops s_we immediately. No partial write occurs after the reset edge, and no ack is issued.
- All outputs are free of combinational paths from req to ack. The s_* outputs are combinational only from sel/state and the selected master's inputs.

## Test plan
- Reset then idle: assert reset mid-cycle → all outputs 0, busy = 0. Hold both req low for 10 cycles → no s_we and no ack.
- Single write by m0: m0_req = 1, we = 1, a = 0x00001004, wd = 0x5 →
  - s_we high for exactly 1 cycle, with s_a = 0x00001004 and s_wd = 0x5.
  - m0_ack pulses 2 cycles after the req sample.
  - LEDs = 0x5.
- Single read by m1: switches = 0xA, m1 reads 0x00001000 → m1_ack pulse with m1_rd = 0x0000000A; m0_rd is unchanged.
- Simultaneous requests from reset:
  - m0 writes 0x00001008 = 0x3F and m1 writes 0x0000100C = 0x06, both raised in the same cycle.
  - m0 is served first; m1's ack arrives exactly 3 cycles after m0's.
  - Both displays are updated.
- Continuous contention: both req held high for 12 cycles → grants alternate 0, 1, 0, 1 with 4 acks total. No master receives two consecutive grants.
- Reset during ACCESS of a write to 0x00001004 → s_we is low immediately, no ack is issued, and the FSM is in IDLE after reset release.

Source files
------------

// File: rtl/io_bus_arbiter.sv
// -----------------------------------------------------------------------------
// io_bus_arbiter
//
// Two-master round-robin arbiter in front of the single memory-mapped I/O
// slave port (switches, LEDs, two 7-segment displays). Master 0 is the CPU
// data port and master 1 is the UART debug bridge.
//
// Every transaction takes three cycles: IDLE (request sampled), ACCESS
// (slave driven, read data captured) and DONE (ack pulse). Only one
// transaction reaches the slave at a time. The slave write enable is high
// for exactly the one ACCESS cycle of a write.
//
// Ports
//   clk                    system clock, rising edge
//   reset                  asynchronous, active-high reset
//   m0_req / m1_req        master i requests a transaction
//   m0_we  / m1_we         1 = write, 0 = read
//   m0_a   / m1_a          transaction address (AW bits)
//   m0_wd  / m1_wd         write data (DW bits)
//   m0_funct3 / m1_funct3  access size/type, forwarded to the slave unchanged
//   m0_ack / m1_ack        one-cycle completion pulse, registered
//   m0_rd  / m1_rd         registered read data, held until that master's next access
//   s_we, s_a, s_wd, s_funct3  slave request, driven only during ACCESS
//   s_rd                   slave combinational read data
//   busy                   high while a transaction is in flight, registered
// -----------------------------------------------------------------------------
module io_bus_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          reset,
   // master 0: CPU data port
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_a,
   input  logic [DW-1:0] m0_wd,
   input  logic [2:0]    m0_funct3,
   output logic          m0_ack,
   output logic [DW-1:0] m0_rd,
   // master 1: UART debug bridge
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_a,
   input  logic [DW-1:0] m1_wd,
   input  logic [2:0]    m1_funct3,
   output logic          m1_ack,
   output logic [DW-1:0] m1_rd,
   // shared slave port
   output logic          s_we,
   output logic [AW-1:0] s_a,
   output logic [DW-1:0] s_wd,
   output logic [2:0]    s_funct3,
   input  logic [DW-1:0] s_rd,
   // status
   output logic          busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t        state_q;
   logic          last_q;      // index of the master granted most recently
   logic          sel_q;       // index of the master owning the current transaction
   logic          m0_ack_q;
   logic          m1_ack_q;
   logic [DW-1:0] m0_rd_q;
   logic [DW-1:0] m1_rd_q;
   logic          busy_q;

   logic          req_any_s;
   logic          grant_d;     // winner if a transaction starts this cycle

   // Round-robin pick: on a tie the master that did not win last time goes.
   always_comb begin
      req_any_s = m0_req | m1_req;
      grant_d   = 1'b0;
      if (m0_req && m1_req) begin
         grant_d = ~last_q;
      end else if (m1_req) begin
         grant_d = 1'b1;
      end else begin
         grant_d = 1'b0;
      end
   end

   // Transaction FSM with its registered outputs (acks, read data, busy).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;         // master 0 wins the first tie
         sel_q    <= 1'b0;
         m0_ack_q <= 1'b0;
         m1_ack_q <= 1'b0;
         m0_rd_q  <= {DW{1'b0}};
         m1_rd_q  <= {DW{1'b0}};
         busy_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               m0_ack_q <= 1'b0;
               m1_ack_q <= 1'b0;
               if (req_any_s) begin
                  sel_q   <= grant_d;
                  last_q  <= grant_d;
                  busy_q  <= 1'b1;
                  state_q <= ACCESS;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            ACCESS: begin
               // Read data is captured on writes as well; the master simply
               // ignores it. The ack register rises so it is high during DONE.
               if (sel_q) begin
                  m1_rd_q  <= s_rd;
                  m1_ack_q <= 1'b1;
               end else begin
                  m0_rd_q  <= s_rd;
                  m0_ack_q <= 1'b1;
               end
               busy_q  <= 1'b1;
               state_q <= DONE;
            end
            DONE: begin
               m0_ack_q <= 1'b0;
               m1_ack_q <= 1'b0;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
            default: begin
               m0_ack_q <= 1'b0;
               m1_ack_q <= 1'b0;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
         endcase
      end
   end

   // Slave port mux: only the selected master is visible, and only in ACCESS.
   // Because state_q resets asynchronously, a reset during ACCESS drops s_we
   // at once and no partial write can follow.
   always_comb begin
      s_we     = 1'b0;
      s_a      = {AW{1'b0}};
      s_wd     = {DW{1'b0}};
      s_funct3 = 3'b000;
      if (state_q == ACCESS) begin
         if (sel_q) begin
            s_we     = m1_we;
            s_a      = m1_a;
            s_wd     = m1_wd;
            s_funct3 = m1_funct3;
         end else begin
            s_we     = m0_we;
            s_a      = m0_a;
            s_wd     = m0_wd;
            s_funct3 = m0_funct3;
         end
      end else begin
         s_we     = 1'b0;
         s_a      = {AW{1'b0}};
         s_wd     = {DW{1'b0}};
         s_funct3 = 3'b000;
      end
   end

   assign m0_ack = m0_ack_q;
   assign m1_ack = m1_ack_q;
   assign m0_rd  = m0_rd_q;
   assign m1_rd  = m1_rd_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_io_bus_arbiter
//
// Directed bench for io_bus_arbiter with a small model of the I/O slave
// (switches at 0x1000, LEDs at 0x1004, displays at 0x1008 and 0x100C).
// -----------------------------------------------------------------------------
module tb_io_bus_arbiter;

   logic        clk;
   logic        reset;
   logic        m0_req, m1_req, m0_we, m1_we;
   logic [31:0] m0_a, m1_a, m0_wd, m1_wd;
   logic [2:0]  m0_funct3, m1_funct3;
   logic        m0_ack, m1_ack;
   logic [31:0] m0_rd, m1_rd;
   logic        s_we;
   logic [31:0] s_a, s_wd, s_rd;
   logic [2:0]  s_funct3;
   logic        busy;

   // slave model state
   logic [31:0] sw_v   = 32'h0;
   logic [31:0] leds   = 32'h0;
   logic [31:0] seg0   = 32'h0;
   logic [31:0] seg1   = 32'h0;

   int n_total = 0;
   int n_bad   = 0;
   int we_cnt  = 0;
   int ack_cnt = 0;
   int base_we, base_ack;
   int grants[$];

   io_bus_arbiter #(.AW(32), .DW(32)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_a(m0_a), .m0_wd(m0_wd),
      .m0_funct3(m0_funct3), .m0_ack(m0_ack), .m0_rd(m0_rd),
      .m1_req(m1_req), .m1_we(m1_we), .m1_a(m1_a), .m1_wd(m1_wd),
      .m1_funct3(m1_funct3), .m1_ack(m1_ack), .m1_rd(m1_rd),
      .s_we(s_we), .s_a(s_a), .s_wd(s_wd), .s_funct3(s_funct3),
      .s_rd(s_rd), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // slave read mux
   always_comb begin
      case (s_a)
         32'h0000_1000: s_rd = sw_v;
         32'h0000_1004: s_rd = leds;
         32'h0000_1008: s_rd = seg0;
         32'h0000_100C: s_rd = seg1;
         default:       s_rd = 32'h0;
      endcase
   end

   // slave write port
   always @(posedge clk) begin
      if (s_we) begin
         case (s_a)
            32'h0000_1004: leds <= s_wd;
            32'h0000_1008: seg0 <= s_wd;
            32'h0000_100C: seg1 <= s_wd;
            default: ;
         endcase
      end
   end

   // event counters sampled mid-cycle
   always @(negedge clk) begin
      if (s_we) we_cnt <= we_cnt + 1;
      if (m0_ack || m1_ack) ack_cnt <= ack_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
      m0_a = 32'h0; m1_a = 32'h0; m0_wd = 32'h0; m1_wd = 32'h0;
      m0_funct3 = 3'b000; m1_funct3 = 3'b000;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      tick(); tick();

      // ---- reset asserted mid-cycle, then idle
      #2 reset = 1'b1;
      #1;
      check("rst_m0_ack", {31'b0, m0_ack}, 32'h0);
      check("rst_m1_ack", {31'b0, m1_ack}, 32'h0);
      check("rst_m0_rd", m0_rd, 32'h0);
      check("rst_m1_rd", m1_rd, 32'h0);
      check("rst_s_we", {31'b0, s_we}, 32'h0);
      check("rst_s_a", s_a, 32'h0);
      check("rst_s_wd", s_wd, 32'h0);
      check("rst_s_f3", {29'b0, s_funct3}, 32'h0);
      check("rst_busy", {31'b0, busy}, 32'h0);
      @(negedge clk) reset = 1'b0;
      base_we = we_cnt; base_ack = ack_cnt;
      repeat (10) tick();
      check("idle_we", 32'(we_cnt - base_we), 32'h0);
      check("idle_ack", 32'(ack_cnt - base_ack), 32'h0);

      // ---- single write by m0 to LEDs
      base_we = we_cnt;
      m0_we = 1'b1; m0_a = 32'h0000_1004; m0_wd = 32'h5; m0_funct3 = 3'b010;
      m0_req = 1'b1;
      tick();                                   // ACCESS
      check("wr_busy", {31'b0, busy}, 32'h1);
      check("wr_s_we", {31'b0, s_we}, 32'h1);
      check("wr_s_a", s_a, 32'h0000_1004);
      check("wr_s_wd", s_wd, 32'h5);
      check("wr_s_f3", {29'b0, s_funct3}, 32'h2);
      check("wr_ack_early", {31'b0, m0_ack}, 32'h0);
      m0_req = 1'b0;
      tick();                                   // DONE
      check("wr_m0_ack", {31'b0, m0_ack}, 32'h1);
      check("wr_m1_ack", {31'b0, m1_ack}, 32'h0);
      check("wr_s_we_off", {31'b0, s_we}, 32'h0);
      check("wr_s_a_off", s_a, 32'h0);
      check("wr_leds", leds, 32'h5);
      tick();                                   // IDLE
      check("wr_ack_drop", {31'b0, m0_ack}, 32'h0);
      check("wr_busy_end", {31'b0, busy}, 32'h0);
      check("wr_we_cycles", 32'(we_cnt - base_we), 32'h1);

      // ---- m0 reads LEDs back so m0_rd holds a known value
      m0_we = 1'b0; m0_req = 1'b1;
      tick();
      m0_req = 1'b0;
      tick();
      check("rd0_ack", {31'b0, m0_ack}, 32'h1);
      check("rd0_data", m0_rd, 32'h5);
      tick();

      // ---- single read by m1 of switches
      sw_v = 32'hA;
      m1_we = 1'b0; m1_a = 32'h0000_1000; m1_req = 1'b1;
      tick();
      m1_req = 1'b0;
      tick();
      check("rd1_ack", {31'b0, m1_ack}, 32'h1);
      check("rd1_m0_ack", {31'b0, m0_ack}, 32'h0);
      check("rd1_data", m1_rd, 32'h0000_000A);
      check("rd1_m0_hold", m0_rd, 32'h5);
      tick();

      // ---- simultaneous requests straight after reset
      #2 reset = 1'b1;
      #1;
      check("rst2_m0_rd", m0_rd, 32'h0);
      check("rst2_m1_rd", m1_rd, 32'h0);
      @(negedge clk) reset = 1'b0;
      m0_we = 1'b1; m0_a = 32'h0000_1008; m0_wd = 32'h3F;
      m1_we = 1'b1; m1_a = 32'h0000_100C; m1_wd = 32'h06;
      m0_req = 1'b1; m1_req = 1'b1;
      tick();                                   // ACCESS for m0
      check("tie_s_a0", s_a, 32'h0000_1008);
      check("tie_s_wd0", s_wd, 32'h3F);
      m0_req = 1'b0;
      tick();                                   // m0 ack
      check("tie_m0_ack", {31'b0, m0_ack}, 32'h1);
      check("tie_m1_ack_no", {31'b0, m1_ack}, 32'h0);
      check("tie_seg0", seg0, 32'h3F);
      tick();                                   // IDLE
      check("tie_gap1", {31'b0, m1_ack}, 32'h0);
      tick();                                   // ACCESS for m1
      check("tie_s_a1", s_a, 32'h0000_100C);
      check("tie_gap2", {31'b0, m1_ack}, 32'h0);
      tick();                                   // m1 ack, 3 cycles after m0's
      check("tie_m1_ack", {31'b0, m1_ack}, 32'h1);
      check("tie_seg1", seg1, 32'h06);
      m1_req = 1'b0;
      tick();

      // ---- continuous contention: last winner was m1, so m0 goes first
      m0_we = 1'b0; m0_a = 32'h0000_1000;
      m1_we = 1'b0; m1_a = 32'h0000_1004;
      leds = 32'h5;
      m0_req = 1'b1; m1_req = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (m0_ack && m1_ack) check("cont_dual_ack", 32'h1, 32'h0);
         if (m0_ack) grants.push_back(0);
         if (m1_ack) grants.push_back(1);
      end
      m0_req = 1'b0; m1_req = 1'b0;
      check("cont_n_acks", 32'(grants.size()), 32'h4);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("cont_grant%0d", k),
               (grants.size() > k) ? 32'(grants[k]) : 32'hF, 32'(k % 2));
      end
      check("cont_m0_rd", m0_rd, 32'h0000_000A);
      check("cont_m1_rd", m1_rd, 32'h5);
      tick(); tick();
      check("cont_busy_end", {31'b0, busy}, 32'h0);

      // ---- reset during the ACCESS of a write
      m0_we = 1'b1; m0_a = 32'h0000_1004; m0_wd = 32'h9; m0_req = 1'b1;
      tick();
      check("ra_s_we", {31'b0, s_we}, 32'h1);
      m0_req = 1'b0;
      base_ack = ack_cnt;
      #2 reset = 1'b1;
      #1;
      check("ra_s_we_drop", {31'b0, s_we}, 32'h0);
      check("ra_s_a_drop", s_a, 32'h0);
      check("ra_busy", {31'b0, busy}, 32'h0);
      tick();
      check("ra_leds_hold", leds, 32'h5);
      @(negedge clk) reset = 1'b0;
      repeat (3) tick();
      check("ra_no_ack", 32'(ack_cnt - base_ack), 32'h0);
      check("ra_idle", {31'b0, busy}, 32'h0);
      check("ra_leds_end", leds, 32'h5);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
